// File: rtl/bist_pkg.sv
// Shared types and helpers for the BIST sweep scheduler.
// Optional retry support is selected with the BIST_SCHED_RETRY_EN macro.
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    LAUNCH,
    WAIT_BUSY,
    RUN,
    RECORD,
    DONE
  } sched_state_t;

  localparam int          DEF_TIMEOUT_CYCLES   = 4096;
  localparam int          DEF_BUSY_WAIT_CYCLES = 16;
  localparam logic [31:0] DEF_SEED             = 32'hdeadbeef;

  // Each link gets the base seed offset by its index, wrapping mod 2^32.
  function automatic logic [31:0] seed_for_link(input logic [31:0] base,
                                                input logic [31:0] link);
    return base + link;
  endfunction

endpackage

// File: rtl/bist_scheduler_if.sv
// Register-side and sender-side signal bundle for bist_scheduler.
// retry_vec exists only when BIST_SCHED_RETRY_EN is defined.
interface bist_scheduler_if #(
  parameter int NUM_LINKS = 4
);
  localparam int CUR_W = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;

  logic                 start;
  logic                 abort;
  logic [NUM_LINKS-1:0] link_mask;
  logic [NUM_LINKS-1:0] sender_start;
  logic [31:0]          sender_seed;
  logic [NUM_LINKS-1:0] sender_busy;
  logic [NUM_LINKS-1:0] sender_pass;
  logic                 busy;
  logic                 done;
  logic [CUR_W-1:0]     cur_link;
  logic [NUM_LINKS-1:0] pass_vec;
  logic [NUM_LINKS-1:0] fail_vec;
  logic [NUM_LINKS-1:0] timeout_vec;

`ifdef BIST_SCHED_RETRY_EN
  logic [NUM_LINKS-1:0] retry_vec;

  modport slave (
    input  start, abort, link_mask, sender_busy, sender_pass,
    output sender_start, sender_seed, busy, done, cur_link,
           pass_vec, fail_vec, timeout_vec, retry_vec
  );

  modport master (
    output start, abort, link_mask, sender_busy, sender_pass,
    input  sender_start, sender_seed, busy, done, cur_link,
           pass_vec, fail_vec, timeout_vec, retry_vec
  );
`else
  modport slave (
    input  start, abort, link_mask, sender_busy, sender_pass,
    output sender_start, sender_seed, busy, done, cur_link,
           pass_vec, fail_vec, timeout_vec
  );

  modport master (
    output start, abort, link_mask, sender_busy, sender_pass,
    input  sender_start, sender_seed, busy, done, cur_link,
           pass_vec, fail_vec, timeout_vec
  );
`endif

endinterface

// File: rtl/bist_watchdog.sv
// Loadable up-counter with clear, enable and a programmable terminal-count
// flag; bounds both the busy-rise wait and the run time of a BIST sender.
module bist_watchdog #(
  parameter int CNT_W = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt_q;

  // Counter: clear beats load beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tc = (cnt_q == tc_val);

endmodule

// File: rtl/bist_scheduler.sv
// Sweeps built-in self-test over NUM_LINKS sender engines, one at a time:
// launch with a per-link seed, wait for busy, bound run time, record result.
// Defining BIST_SCHED_RETRY_EN relaunches a failing (non-timeout) link once
// and adds retry_vec.
module bist_scheduler
  import bist_pkg::*;
#(
  parameter int          NUM_LINKS        = 4,
  parameter logic [31:0] SEED             = DEF_SEED,
  parameter int          TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
  parameter int          BUSY_WAIT_CYCLES = DEF_BUSY_WAIT_CYCLES
) (
  input logic             clk,
  input logic             reset,
  bist_scheduler_if.slave bus
);

  // idx needs one extra bit so that idx == NUM_LINKS marks the end of a sweep.
  localparam int IW      = $clog2(NUM_LINKS) + 1;
  localparam int CUR_W   = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1;
  localparam int MAX_LIM = (TIMEOUT_CYCLES > BUSY_WAIT_CYCLES) ? TIMEOUT_CYCLES : BUSY_WAIT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_LIM) + 1;

  localparam logic [IW-1:0]    IDX_END = IW'(NUM_LINKS);
  localparam logic [CUR_W-1:0] CUR_MAX = CUR_W'(NUM_LINKS - 1);
  localparam logic [CNT_W-1:0] TC_RUN  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TC_WAIT = CNT_W'(BUSY_WAIT_CYCLES - 1);

  sched_state_t         state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [NUM_LINKS-1:0] mask_q;
  logic [NUM_LINKS-1:0] pass_q, fail_q, tmo_q;
  logic                 pass_cap_q;
  logic [CUR_W-1:0]     cur;
  logic                 lk_busy, lk_mask, link_active;
  logic                 sweep_start, rec_result, rec_timeout;
  logic                 tmr_clr, tmr_en, tmr_tc;
  logic [CNT_W-1:0]     tmr_tc_val;
`ifdef BIST_SCHED_RETRY_EN
  logic                 retry_set, retried_q;
  logic [NUM_LINKS-1:0] retry_q;
`endif

  assign cur         = (idx_q >= IDX_END) ? CUR_MAX : idx_q[CUR_W-1:0];
  assign lk_busy     = bus.sender_busy[cur];
  assign lk_mask     = mask_q[cur];
  assign link_active = (state_q == LAUNCH) || (state_q == WAIT_BUSY) ||
                       (state_q == RUN)    || (state_q == RECORD);
  assign tmr_tc_val  = (state_q == WAIT_BUSY) ? TC_WAIT : TC_RUN;

  bist_watchdog #(
    .CNT_W (CNT_W)
  ) u_wdog (
    .clk      (clk),
    .rst      (reset),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .load     (1'b0),
    .load_val ('0),
    .tc_val   (tmr_tc_val),
    .tc       (tmr_tc)
  );

  // Next-state and per-cycle actions; abort overrides everything mid-sweep.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sweep_start = 1'b0;
    rec_result  = 1'b0;
    rec_timeout = 1'b0;
    tmr_clr     = 1'b0;
    tmr_en      = 1'b0;
`ifdef BIST_SCHED_RETRY_EN
    retry_set   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          sweep_start = 1'b1;
          idx_d       = '0;
          state_d     = SELECT;
        end
      end
      SELECT: begin
        if (idx_q == IDX_END) begin
          state_d = DONE;
        end else if (lk_mask) begin
          state_d = LAUNCH;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      LAUNCH: begin
        tmr_clr = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (lk_busy) begin
          tmr_clr = 1'b1;
          state_d = RUN;
        end else if (tmr_tc) begin
          rec_timeout = 1'b1;
          idx_d       = idx_q + IW'(1);
          state_d     = SELECT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      RUN: begin
        // Completion is checked first so it wins over a coincident timeout.
        if (!lk_busy) begin
          state_d = RECORD;
        end else if (tmr_tc) begin
          rec_timeout = 1'b1;
          idx_d       = idx_q + IW'(1);
          state_d     = SELECT;
        end else begin
          tmr_en = 1'b1;
        end
      end
      RECORD: begin
`ifdef BIST_SCHED_RETRY_EN
        if (!pass_cap_q && !retried_q) begin
          retry_set = 1'b1;
          state_d   = LAUNCH;
        end else begin
`else
        begin
`endif
          rec_result = 1'b1;
          idx_d      = idx_q + IW'(1);
          state_d    = SELECT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.abort && (state_q != IDLE) && (state_q != DONE)) begin
      state_d     = DONE;
      idx_d       = idx_q;
      rec_result  = 1'b0;
      rec_timeout = 1'b0;
      tmr_clr     = 1'b0;
      tmr_en      = 1'b0;
`ifdef BIST_SCHED_RETRY_EN
      retry_set   = 1'b0;
`endif
    end
  end

  // State, link index and latched mask.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (sweep_start) begin
        mask_q <= bus.link_mask;
      end
    end
  end

  // Result vectors: cleared by an accepted start, one bit written per link.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_q <= '0;
      fail_q <= '0;
      tmo_q  <= '0;
    end else if (sweep_start) begin
      pass_q <= '0;
      fail_q <= '0;
      tmo_q  <= '0;
    end else if (rec_result) begin
      pass_q[cur] <= pass_cap_q;
      fail_q[cur] <= ~pass_cap_q;
    end else if (rec_timeout) begin
      tmo_q[cur]  <= 1'b1;
      fail_q[cur] <= 1'b1;
    end
  end

  // Capture the compare result in the cycle busy is first seen low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pass_cap_q <= 1'b0;
    end else if ((state_q == RUN) && !lk_busy) begin
      pass_cap_q <= bus.sender_pass[cur];
    end
  end

`ifdef BIST_SCHED_RETRY_EN
  // Retry bookkeeping: one relaunch per link, flagged in retry_vec.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retried_q <= 1'b0;
      retry_q   <= '0;
    end else if (sweep_start) begin
      retried_q <= 1'b0;
      retry_q   <= '0;
    end else if (retry_set) begin
      retried_q    <= 1'b1;
      retry_q[cur] <= 1'b1;
    end else if (idx_d != idx_q) begin
      retried_q <= 1'b0;
    end
  end

  assign bus.retry_vec = retry_q;
`endif

  assign bus.sender_start = (state_q == LAUNCH) ? (NUM_LINKS'(1) << cur) : '0;
  assign bus.sender_seed  = link_active ? seed_for_link(SEED, 32'(cur)) : '0;
  assign bus.busy         = (state_q != IDLE) && (state_q != DONE);
  assign bus.done         = (state_q == DONE);
  assign bus.cur_link     = cur;
  assign bus.pass_vec     = pass_q;
  assign bus.fail_vec     = fail_q;
  assign bus.timeout_vec  = tmo_q;

endmodule
